// File: rtl/vga_capture.sv
// vga_capture: samples a VGA stream in the system clock domain, recovers
// pixel coordinates, verifies frame geometry before locking and delivers
// locked pixels through a small show-ahead valid/ready FIFO.
module vga_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vga_clk,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_sof,
  output logic        locked,
  output logic        sync_err,
  output logic        overflow,
  output logic [9:0]  line_len
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 45;  // {sof, y, x, rgb}
  localparam logic [9:0] H_ACT_C = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT_C = 10'(V_ACTIVE);
  localparam logic [AW:0] CNT_FULL_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Ten-bit increment that sticks at its maximum.
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    if (v == 10'd1023) begin
      sat_inc10 = v;
    end else begin
      sat_inc10 = v + 10'd1;
    end
  endfunction

  logic        s_clk_r, s_hs_r, s_vs_r, s_blank_n_r;
  logic [23:0] s_rgb_r;
  logic        d_clk_r, d_vs_r, d_blank_n_r;
  logic [9:0]  x_cnt_r, y_cnt_r, line_len_r;
  state_t      state_r, next_state_s;
  logic        sync_err_r, sync_err_s, overflow_r;
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;

  // HS carries no information needed here: line ends come from BLANK_n.
  logic unused_hs_s;
  assign unused_hs_s = s_hs_r;

  // Event decode from the registered and once-more-delayed inputs.
  logic pix_ev_s, line_end_s, vs_fall_s, line_mis_s, frame_ok_s;
  logic [9:0] y_after_line_s;
  assign pix_ev_s       = s_clk_r & ~d_clk_r & s_blank_n_r;
  assign line_end_s     = ~s_blank_n_r & d_blank_n_r;
  assign vs_fall_s      = ~s_vs_r & d_vs_r;
  assign line_mis_s     = (line_end_s & (x_cnt_r != H_ACT_C)) |
                          (pix_ev_s & (x_cnt_r == H_ACT_C));
  // A line end coinciding with VS falling is counted before the frame check.
  assign y_after_line_s = line_end_s ? sat_inc10(y_cnt_r) : y_cnt_r;
  assign frame_ok_s     = (y_after_line_s == V_ACT_C);

  // FIFO control.
  logic          full_s, pop_s, push_req_s, push_ok_s;
  logic [EW-1:0] entry_s, head_s;
  assign pix_valid  = (count_r != {(AW+1){1'b0}});
  assign full_s     = (count_r == CNT_FULL_C);
  assign pop_s      = pix_valid & pix_ready;
  assign push_req_s = (state_r == ST_LOCKED) & pix_ev_s & (x_cnt_r != H_ACT_C);
  assign push_ok_s  = push_req_s & (~full_s | pop_s);
  assign entry_s    = {((x_cnt_r == 10'd0) & (y_cnt_r == 10'd0)), y_cnt_r, x_cnt_r, s_rgb_r};
  assign head_s     = mem_r[rd_ptr_r];

  // Register every VGA input once, plus a second stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_clk_r     <= 1'b0;
      s_hs_r      <= 1'b1;
      s_vs_r      <= 1'b1;
      s_blank_n_r <= 1'b0;
      s_rgb_r     <= 24'd0;
      d_clk_r     <= 1'b0;
      d_vs_r      <= 1'b1;
      d_blank_n_r <= 1'b0;
    end else begin
      s_clk_r     <= vga_clk;
      s_hs_r      <= vga_hs;
      s_vs_r      <= vga_vs;
      s_blank_n_r <= vga_blank_n;
      s_rgb_r     <= {vga_r, vga_g, vga_b};
      d_clk_r     <= s_clk_r;
      d_vs_r      <= s_vs_r;
      d_blank_n_r <= s_blank_n_r;
    end
  end

  // Column/row counters and last-line length; frame start wins over line end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt_r    <= 10'd0;
      y_cnt_r    <= 10'd0;
      line_len_r <= 10'd0;
    end else begin
      if (line_end_s) begin
        line_len_r <= x_cnt_r;
      end
      if (vs_fall_s) begin
        x_cnt_r <= 10'd0;
        y_cnt_r <= 10'd0;
      end else if (line_end_s) begin
        x_cnt_r <= 10'd0;
        y_cnt_r <= sat_inc10(y_cnt_r);
      end else if (pix_ev_s && (x_cnt_r != H_ACT_C)) begin
        x_cnt_r <= sat_inc10(x_cnt_r);
      end
    end
  end

  // Lock state register and the registered error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_SEARCH;
      sync_err_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      sync_err_r <= sync_err_s;
    end
  end

  // Lock state transitions: search for a frame start, verify one frame, deliver.
  always_comb begin
    next_state_s = state_r;
    sync_err_s   = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        if (vs_fall_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_SEARCH;
        end
      end
      ST_CHECK: begin
        if (line_mis_s) begin
          next_state_s = ST_SEARCH;
          sync_err_s   = 1'b1;
        end else if (vs_fall_s && frame_ok_s) begin
          next_state_s = ST_LOCKED;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (line_mis_s || (vs_fall_s && !frame_ok_s)) begin
          next_state_s = ST_SEARCH;
          sync_err_s   = 1'b1;
        end else begin
          next_state_s = ST_LOCKED;
        end
      end
      default: begin
        next_state_s = ST_SEARCH;
        sync_err_s   = 1'b0;
      end
    endcase
  end

  // Show-ahead FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= entry_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (push_req_s && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign pix_data = head_s[23:0];
  assign pix_x    = head_s[33:24];
  assign pix_y    = head_s[43:34];
  assign pix_sof  = head_s[44];
  assign locked   = (state_r == ST_LOCKED);
  assign sync_err = sync_err_r;
  assign overflow = overflow_r;
  assign line_len = line_len_r;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture using a reduced geometry so whole frames
// run quickly. Expected pixels are queued as they are driven and compared
// as the consumer pops them.
module tb_vga_capture;

  localparam int H = 16;
  localparam int V = 4;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        vga_clk = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1, vga_blank_n = 1'b0;
  logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
  logic        pix_valid, pix_ready = 1'b1;
  logic [23:0] pix_data;
  logic [9:0]  pix_x, pix_y, line_len;
  logic        pix_sof, locked, sync_err, overflow;

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .vga_clk(vga_clk), .vga_hs(vga_hs),
    .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g),
    .vga_b(vga_b), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof),
    .locked(locked), .sync_err(sync_err), .overflow(overflow), .line_len(line_len)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [44:0] exp_q[$];
  bit allow_drop = 1'b0;
  int drops = 0;
  int popped = 0;
  int err_cnt = 0;
  int stall_left = 0;
  int fid = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Consumer side: count error pulses and compare every popped pixel.
  always @(negedge clk) begin
    logic [44:0] obs;
    if (reset_n && sync_err) err_cnt++;
    if (reset_n && pix_valid && pix_ready) begin
      obs = {pix_sof, pix_y, pix_x, pix_data};
      if (allow_drop) begin
        while (exp_q.size() > 0 && exp_q[0] !== obs && drops < 8) begin
          void'(exp_q.pop_front());
          drops++;
        end
      end
      if (exp_q.size() == 0) begin
        check_val("unexpected_pixel", pix_valid, 0);
      end else begin
        popped++;
        check_val("pixel", obs, exp_q.pop_front());
      end
    end
  end

  task automatic upd_ready();
    pix_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
  endtask

  // One pixel-strobe period (2 clk), inputs changed just after clk edges.
  task automatic tick(input logic blank_n, input logic hs, input logic vs, input logic [23:0] rgb);
    @(posedge clk); #1;
    vga_clk = 1'b0; vga_blank_n = blank_n; vga_hs = hs; vga_vs = vs;
    {vga_r, vga_g, vga_b} = rgb;
    upd_ready();
    @(posedge clk); #1;
    vga_clk = 1'b1;
    upd_ready();
  endtask

  task automatic send_frame(input int bad_line, input int bad_len, input bit cap_in,
                            input int stall_line, input int stall_len, input bit lat_chk);
    bit cap;
    int len;
    logic [23:0] rgb;
    cap = cap_in;
    fid++;
    for (int y = 0; y < V; y++) begin
      len = (y == bad_line) ? bad_len : H;
      for (int x = 0; x < len; x++) begin
        rgb = {8'($urandom_range(0, 255)), 8'(x * 7), 8'(y + fid * 16)};
        if (y == stall_line && x == 2) stall_left = stall_len;
        if (cap && x < H) exp_q.push_back({((x == 0 && y == 0) ? 1'b1 : 1'b0), 10'(y), 10'(x), rgb});
        if (x >= H) cap = 1'b0;
        tick(1'b1, 1'b1, 1'b1, rgb);
        if (lat_chk && x == 0 && y == 0) begin
          @(posedge clk); #1;
          check_val("lat_not_yet_valid", pix_valid, 0);
          @(posedge clk); #1;
          check_val("lat_valid", pix_valid, 1);
          check_val("lat_sof", pix_sof, 1);
          check_val("lat_data", pix_data, rgb);
        end
      end
      tick(1'b0, 1'b1, 1'b1, 24'd0);
      tick(1'b0, 1'b0, 1'b1, 24'd0);
      tick(1'b0, 1'b1, 1'b1, 24'd0);
      if (y == bad_line) begin
        cap = 1'b0;
        check_val("line_len_bad", line_len, (bad_len < H) ? bad_len : H);
      end
    end
    repeat (2) tick(1'b0, 1'b1, 1'b1, 24'd0);
    repeat (2) tick(1'b0, 1'b1, 1'b0, 24'd0);
    repeat (2) tick(1'b0, 1'b1, 1'b1, 24'd0);
  endtask

  task automatic drain_and_count(input string tag, input int exp_pop);
    repeat (10) @(posedge clk);
    #1;
    check_val({tag, "_popped"}, popped, exp_pop);
    check_val({tag, "_q_empty"}, exp_q.size(), 0);
    popped = 0;
  endtask

  int e0;

  initial begin
    // Reset values while reset_n is held low.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", pix_valid, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_line_len", line_len, 0);
    @(posedge clk); #3;
    reset_n = 1'b1;

    // Lock sequence: SEARCH -> CHECK -> LOCKED over two VS falls.
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("locked_after_vs1", locked, 0);
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("locked_after_vs2", locked, 1);

    // Nominal captured frame with latency check.
    send_frame(-1, 0, 1'b1, -1, 0, 1'b1);
    drain_and_count("nominal", H * V);
    check_val("nominal_line_len", line_len, H);
    check_val("nominal_overflow", overflow, 0);
    check_val("nominal_locked", locked, 1);

    // Backpressure 6 clk and 8 clk (the latter hits full with simultaneous pop).
    send_frame(-1, 0, 1'b1, 1, 6, 1'b0);
    drain_and_count("stall6", H * V);
    check_val("stall6_overflow", overflow, 0);
    send_frame(-1, 0, 1'b1, 2, 8, 1'b0);
    drain_and_count("stall8", H * V);
    check_val("stall8_overflow", overflow, 0);

    // Backpressure 12 clk: drops, sticky overflow, continuous after the gap.
    allow_drop = 1'b1;
    drops = 0;
    send_frame(-1, 0, 1'b1, 1, 12, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    allow_drop = 1'b0;
    check_val("stall12_overflow", overflow, 1);
    check_val("stall12_dropped", (drops > 0), 1);
    check_val("stall12_popped", popped + drops, H * V);
    check_val("stall12_q_empty", exp_q.size(), 0);
    popped = 0;
    send_frame(-1, 0, 1'b1, -1, 0, 1'b0);
    drain_and_count("post_ovf", H * V);
    check_val("overflow_sticky", overflow, 1);

    // Short line while locked.
    e0 = err_cnt;
    send_frame(1, H - 1, 1'b1, -1, 0, 1'b0);
    drain_and_count("short", 2 * H - 1);
    check_val("short_err_pulses", err_cnt - e0, 1);
    check_val("short_locked", locked, 0);
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("short_relock", locked, 1);
    send_frame(-1, 0, 1'b1, -1, 0, 1'b0);
    drain_and_count("relock1", H * V);

    // Extra pixel on a line while locked.
    e0 = err_cnt;
    send_frame(2, H + 1, 1'b1, -1, 0, 1'b0);
    drain_and_count("extra", 3 * H);
    check_val("extra_err_pulses", err_cnt - e0, 1);
    check_val("extra_locked", locked, 0);
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("extra_relock", locked, 1);

    // Asynchronous reset with a full FIFO, then relock from scratch.
    send_frame(-1, 0, 1'b1, 0, 100000, 1'b0);
    check_val("prerst_valid", pix_valid, 1);
    check_val("prerst_overflow", overflow, 1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check_val("arst_valid", pix_valid, 0);
    check_val("arst_data", pix_data, 0);
    check_val("arst_xy_sof", {pix_sof, pix_y, pix_x}, 0);
    check_val("arst_locked", locked, 0);
    check_val("arst_err", sync_err, 0);
    check_val("arst_overflow", overflow, 0);
    check_val("arst_line_len", line_len, 0);
    exp_q.delete();
    popped = 0;
    stall_left = 0;
    pix_ready = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b1;
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("rst2_locked_vs1", locked, 0);
    send_frame(-1, 0, 1'b0, -1, 0, 1'b0);
    check_val("rst2_locked_vs2", locked, 1);
    send_frame(-1, 0, 1'b1, -1, 0, 1'b0);
    drain_and_count("rst2", H * V);
    check_val("rst2_overflow", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
